// File: rtl/stack_sequencer.sv
// Two-byte PUSH/POP sequencer between the stack pointer and the byte-wide memory bus.
// Optional bounds checking is enabled by defining STACK_SEQ_BOUNDS_EN.
module stack_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_op_i,
  input  logic [15:0] cmd_data_i,
  input  logic [15:0] sp_i,
  output logic        sp_load_o,
  output logic [15:0] sp_next_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

  state_t      state;
  logic        opQ;
  logic [15:0] spQ;
  logic [7:0]  dataLoQ;
  logic [7:0]  loByte;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic        accept;

  // PUSH pre-decrements (hi byte first); POP reads lo then hi upward.
  assign addr0  = cmd_op_i ? sp_i : sp_i - 16'd1;
  assign addr1  = opQ ? spQ + 16'd1 : spQ - 16'd2;
  assign accept = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      sp_load_o   <= 1'b0;
      sp_next_o   <= 16'h0000;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 16'h0000;
      mem_wdata_o <= 8'h00;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 16'h0000;
      opQ         <= 1'b0;
      spQ         <= 16'h0000;
      dataLoQ     <= 8'h00;
      loByte      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opQ         <= cmd_op_i;
            spQ         <= sp_i;
            dataLoQ     <= cmd_data_i[7:0];
            cmd_ready_o <= 1'b0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= !cmd_op_i;
            mem_addr_o  <= addr0;
            mem_wdata_o <= cmd_op_i ? 8'h00 : cmd_data_i[15:8];
            state       <= BYTE0;
          end
        end
        BYTE0: begin
          if (mem_ack_i) begin
            loByte      <= mem_rdata_i;
            mem_addr_o  <= addr1;
            mem_wdata_o <= dataLoQ;
            state       <= BYTE1;
          end
        end
        BYTE1: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            sp_load_o <= 1'b1;
            sp_next_o <= opQ ? spQ + 16'd2 : spQ - 16'd2;
            if (opQ) begin
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= {mem_rdata_i, loByte};
            end
            state <= DONE;
          end
        end
        DONE: begin
          sp_load_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STACK_SEQ_BOUNDS_EN
  localparam logic [15:0] SP_LOW  = 16'hFF80;
  localparam logic [15:0] SP_HIGH = 16'hFFFE;

  function automatic logic outOfRange(input logic [15:0] a);
    return (a < SP_LOW) || (a > SP_HIGH);
  endfunction

  // Each address is checked on the edge that puts it on the bus.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_o <= 1'b0;
    else if ((state == IDLE && accept && outOfRange(addr0)) ||
             (state == BYTE0 && mem_ack_i && outOfRange(addr1)))
      err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed cases plus randomized PUSH/POP
// against a byte-array memory model and spec-level address/SP rules.
module tb_stack_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdOp;
  logic [15:0] cmdData;
  logic [15:0] sp;
  logic        spLoad;
  logic [15:0] spNext;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [7:0]  memWdata;
  logic        memAck;
  logic [7:0]  memRdata;
  logic        rspValid;
  logic [15:0] rspData;
  logic        err;

  int nTests = 0;
  int nFail  = 0;
  logic [7:0]  tbMem [0:65535];
  bit          expErr;
  logic [15:0] lastRsp;

`ifdef STACK_SEQ_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady),
    .cmd_op_i(cmdOp), .cmd_data_i(cmdData), .sp_i(sp), .sp_load_o(spLoad),
    .sp_next_o(spNext), .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_ack_i(memAck), .mem_rdata_i(memRdata),
    .rsp_valid_o(rspValid), .rsp_data_o(rspData), .err_o(err)
  );

  function automatic bit outside(input logic [15:0] a);
    return BOUNDS && ((a < 16'hFF80) || (a > 16'hFFFE));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic doOp(input bit op, input logic [15:0] data, input logic [15:0] spv,
                      input int w0, input int w1, input bit holdValid, input bit strayAck);
    logic [15:0] a [2];
    logic [7:0]  wb [2];
    int          w [2];
    logic [15:0] expSp;
    logic [15:0] expRsp;
    a[0]   = op ? spv : spv - 16'd1;
    a[1]   = op ? spv + 16'd1 : spv - 16'd2;
    wb[0]  = data[15:8];
    wb[1]  = data[7:0];
    w[0]   = w0;
    w[1]   = w1;
    expSp  = op ? spv + 16'd2 : spv - 16'd2;
    expRsp = {tbMem[a[1]], tbMem[a[0]]};
    chk("idle_ready", 32'(cmdReady), 32'd1);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdData  = data;
    sp       = spv;
    for (int b = 0; b < 2; b++) begin
      expErr = expErr | outside(a[b]);
      for (int k = 0; k <= w[b]; k++) begin
        @(negedge clk);
        if (b == 0 && k == 0) begin
          if (!holdValid) cmdValid = 1'b0;
          cmdData = 16'($urandom);
          sp      = 16'($urandom);
        end
        chk("req", 32'(memReq), 32'd1);
        chk("addr", 32'(memAddr), 32'(a[b]));
        chk("we", 32'(memWe), 32'(!op));
        if (!op) chk("wdata", 32'(memWdata), 32'(wb[b]));
        chk("busy_ready", 32'(cmdReady), 32'd0);
        chk("busy_spload", 32'(spLoad), 32'd0);
        chk("busy_rspvalid", 32'(rspValid), 32'd0);
        chk("busy_err", 32'(err), 32'(expErr));
        memAck   = (k == w[b]);
        memRdata = (k == w[b] && op) ? tbMem[a[b]] : 8'($urandom);
        if (k == w[b] && !op) tbMem[a[b]] = wb[b];
      end
    end
    @(negedge clk);
    memAck = strayAck;
    chk("done_spload", 32'(spLoad), 32'd1);
    chk("done_spnext", 32'(spNext), 32'(expSp));
    chk("done_req", 32'(memReq), 32'd0);
    chk("done_rspvalid", 32'(rspValid), 32'(op));
    chk("done_rspdata", 32'(rspData), 32'(op ? expRsp : lastRsp));
    chk("done_ready", 32'(cmdReady), 32'd0);
    chk("done_err", 32'(err), 32'(expErr));
    if (op) lastRsp = expRsp;
    @(negedge clk);
    memAck = 1'b0;
    chk("post_spload", 32'(spLoad), 32'd0);
    chk("post_rspvalid", 32'(rspValid), 32'd0);
    chk("post_ready", 32'(cmdReady), 32'd1);
    chk("post_req", 32'(memReq), 32'd0);
    chk("post_rsphold", 32'(rspData), 32'(lastRsp));
    chk("post_err", 32'(err), 32'(expErr));
  endtask

  initial begin
    rst = 1'b1; cmdValid = 1'b0; cmdOp = 1'b0; cmdData = 16'h0; sp = 16'h0;
    memAck = 1'b0; memRdata = 8'h0;
    for (int i = 0; i < 65536; i++) tbMem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmdReady), 32'd1);
    chk("rst_spload", 32'(spLoad), 32'd0);
    chk("rst_spnext", 32'(spNext), 32'd0);
    chk("rst_req", 32'(memReq), 32'd0);
    chk("rst_we", 32'(memWe), 32'd0);
    chk("rst_addr", 32'(memAddr), 32'd0);
    chk("rst_wdata", 32'(memWdata), 32'd0);
    chk("rst_rspvalid", 32'(rspValid), 32'd0);
    chk("rst_rspdata", 32'(rspData), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    expErr = 1'b0;
    lastRsp = 16'h0;
    @(negedge clk);

    doOp(1'b0, 16'hBEEF, 16'hFFFE, 0, 0, 1'b0, 1'b0);
    chk("push_mem_hi", 32'(tbMem[16'hFFFD]), 32'h0BE);

    tbMem[16'hC000] = 8'h34;
    tbMem[16'hC001] = 8'h12;
    doOp(1'b1, 16'h0000, 16'hC000, 2, 2, 1'b0, 1'b0);
    chk("pop_wait_rsp", 32'(rspData), 32'h1234);
    chk("pop_wait_sp", 32'(spNext), 32'hC002);

    doOp(1'b0, 16'h5566, 16'h0000, 0, 0, 1'b0, 1'b0);
    chk("wrap_push_sp", 32'(spNext), 32'hFFFE);
    doOp(1'b1, 16'h0000, 16'hFFFF, 0, 0, 1'b0, 1'b0);
    chk("wrap_pop_sp", 32'(spNext), 32'h0001);

    // Valid held through a PUSH, stray ack in DONE, back-to-back POP.
    doOp(1'b0, 16'h1234, 16'hFFF0, 0, 1, 1'b1, 1'b1);
    doOp(1'b1, 16'h0000, 16'hFFEE, 1, 0, 1'b0, 1'b0);
    chk("b2b_pop_rsp", 32'(rspData), 32'h1234);

    memAck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_req", 32'(memReq), 32'd0);
      chk("stray_ready", 32'(cmdReady), 32'd1);
      chk("stray_spload", 32'(spLoad), 32'd0);
    end
    memAck = 1'b0;

    // Reset during BYTE1 of a PUSH.
    cmdValid = 1'b1; cmdOp = 1'b0; cmdData = 16'hA1B2; sp = 16'hD000;
    @(negedge clk);
    cmdValid = 1'b0;
    chk("mid_addr0", 32'(memAddr), 32'hCFFF);
    memAck = 1'b1;
    @(negedge clk);
    chk("mid_addr1", 32'(memAddr), 32'hCFFE);
    memAck = 1'b0;
    rst = 1'b1;
    tbMem[16'hCFFF] = 8'hA1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", 32'(memReq), 32'd0);
    chk("mid_rst_ready", 32'(cmdReady), 32'd1);
    chk("mid_rst_spload", 32'(spLoad), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_rsp", 32'(rspData), 32'd0);
    expErr = 1'b0;
    lastRsp = 16'h0;
    @(negedge clk);
    chk("mid_rst_spload2", 32'(spLoad), 32'd0);

    doOp(1'b0, 16'hABCD, 16'hFF80, 0, 0, 1'b0, 1'b0);
    doOp(1'b1, 16'h0000, 16'hFFF8, 0, 0, 1'b0, 1'b0);
    chk("bounds_sticky", 32'(err), 32'(BOUNDS));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expErr = 1'b0;
    lastRsp = 16'h0;
    chk("bounds_clear", 32'(err), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      bit          rop;
      logic [15:0] rsp;
      rop = 1'($urandom_range(0, 1));
      rsp = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hFF7E, 16'hFFFF))
                                         : 16'($urandom);
      doOp(rop, 16'($urandom), rsp, $urandom_range(0, 3), $urandom_range(0, 3),
           (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Two-byte stack transfer sequencer for the CPU; sits directly downstream of the stack pointer and upstream of the memory bus. Accepts one PUSH or POP command, reads the current SP, and runs two byte-wide memory cycles at SP-relative addresses in Game Boy order. It returns popped data to the CPU core and loads the updated SP value back into the stack pointer.

## Interface
- SP_LOW, 16'hFF80, lowest legal stack byte address (bounds check only)
- SP_HIGH, 16'hFFFE, highest legal stack byte address (bounds check only)

- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_op_i  in  1  0 = PUSH, 1 = POP
- cmd_data_i  in  16  PUSH data; {hi, lo}
- sp_i  in  16  current SP from stack pointer; sampled at accept
- sp_load_o  out  1  one-cycle strobe: load sp_next_o into SP
- sp_next_o  out  16  new SP value
- mem_req_o  out  1  memory cycle request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  16  byte address
- mem_wdata_o  out  8  write byte
- mem_ack_i  in  1  cycle complete; sampled only while mem_req_o = 1
- mem_rdata_i  in  8  read byte, valid with mem_ack_i
- rsp_valid_o  out  1  one-cycle strobe: POP result valid
- rsp_data_o  out  16  POP result {hi, lo}
- err_o  out  1  sticky bounds error (bounds check build only)

## Operation
- States: IDLE, BYTE0, BYTE1, DONE.
- IDLE: cmd_ready_o = 1. On valid&&ready, capture op, data, and sp_i into sp_q, then go to BYTE0. All other states: cmd_ready_o = 0, and cmd_valid_i is ignored.
- PUSH: BYTE0 writes cmd_data[15:8] to sp_q-1. BYTE1 writes cmd_data[7:0] to sp_q-2. sp_next_o = sp_q-2.
- POP: BYTE0 reads sp_q into lo. BYTE1 reads sp_q+1 into hi. sp_next_o = sp_q+2. rsp_data_o = {hi, lo}.
- BYTE0/BYTE1: mem_req_o = 1. mem_addr_o, mem_we_o and mem_wdata_o stay stable until mem_ack_i. Advance on the edge where mem_ack_i = 1. Wait states of any length are allowed.
- DONE: sp_load_o = 1 for exactly one cycle. For POP, rsp_valid_o = 1 in the same cycle. Then go to IDLE.
- rsp_valid_o never pulses for PUSH. rsp_data_o holds its last value between pulses.
- Address arithmetic is 16-bit modulo 2^16:
  - PUSH at SP = 0x0000 writes 0xFFFF, then 0xFFFE; new SP = 0xFFFE.
  - POP at SP = 0xFFFF reads 0xFFFF, then 0x0000; new SP = 0x0001.
- mem_ack_i while mem_req_o = 0 is ignored.

## Timing
- Reset values: cmd_ready_o = 1, sp_load_o = 0, sp_next_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, rsp_valid_o = 0, rsp_data_o = 0, err_o = 0. State = IDLE.
- Zero-wait latency, with the command accepted on edge N:
  - BYTE0 request in cycle N+1, acked in N+1.
  - BYTE1 in cycle N+2.
  - DONE strobes in cycle N+3.
  - Next command accepted at edge N+4.
- Each wait cycle on mem_ack_i adds one cycle.
- Reset mid-operation returns to IDLE on that edge. mem_req_o drops immediately and the SP load never occurs. A partially completed PUSH leaves memory written but SP unchanged.

## Configuration
- STACK_SEQ_BOUNDS_EN defined:
  - Each byte address is checked as its request is issued.
  - Any address outside [SP_LOW, SP_HIGH] sets err_o on that edge.
  - err_o stays set until rst_i.
  - The transfer still completes normally.
- Undefined: err_o is tied to 0, no compare logic is present, and SP_LOW/SP_HIGH are ignored.

## Test plan
- PUSH 0xBEEF, SP = 0xFFFE, zero-wait ack -> writes 0xBE@0xFFFD, then 0xEF@0xFFFC; sp_load_o with 0xFFFC in cycle N+3; no rsp_valid_o.
- POP, SP = 0xC000, memory 0xC000 = 0x34, 0xC001 = 0x12, 2 wait cycles per byte -> address/we stable while waiting; rsp_data_o = 0x1234 and sp_next_o = 0xC002, both strobed at N+7.
- Wrap: PUSH 0x5566 at SP = 0x0000 -> writes 0x55@0xFFFF, 0x66@0xFFFE, new SP = 0xFFFE. POP at SP = 0xFFFF -> reads 0xFFFF, 0x0000, new SP = 0x0001.
- cmd_valid_i held high through a PUSH -> second command accepted only at N+4; stray mem_ack_i pulses in IDLE/DONE cause no state change.
- rst_i asserted during BYTE1 of a PUSH -> next edge: mem_req_o = 0, cmd_ready_o = 1, no sp_load_o pulse.
- With STACK_SEQ_BOUNDS_EN, SP = 0xFF80, PUSH -> err_o = 1 from the BYTE0 request edge, transfer completes, err_o stays 1 until reset. Without the macro, err_o stays 0.
